decoder_seq: RTL and testbench

- Parametrised, registered successor to the 4-to-16 active-low decoder.
- Decodes an AW-bit address to OUTS active-low one-hot lines in three modes:
  - direct: registered decode of the address input.
  - latched: address is held in a register, 74x137 style.
  - scan: an internal counter steps through the lines, for generating timing and phase strobes.
- Used wherever the CPU needs registered strobe decoding or a stepped one-hot sequence.

---
 rtl/decoder_pkg.sv | 16 +
 rtl/onehot_dec.sv | 24 ++
 rtl/decoder_seq.sv | 158 +++++++++++++++
 tb/tb_decoder_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the registered decoder: mode encodings and scan states.
package decoder_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_DIRECT = 2'd0;
   localparam mode_t MODE_LATCH  = 2'd1;
   localparam mode_t MODE_SCAN   = 2'd2;
   localparam mode_t MODE_RSVD   = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } scan_st_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational AW-to-OUTS active-high one-hot decoder with enable.
// Addresses at or beyond OUTS select no line.
module onehot_dec #(
   parameter int AW   = 4,
   parameter int OUTS = 16
) (
   input  logic [AW-1:0]   i_addr,
   input  logic            i_en,
   output logic [OUTS-1:0] o_hot
);

   // One compare per output line.
   always_comb begin
      o_hot = '0;
      for (int i = 0; i < OUTS; i++) begin
         if (i_en && (i_addr == AW'(i))) begin
            o_hot[i] = 1'b1;
         end else begin
            o_hot[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/decoder_seq.sv
// Registered active-low decoder with direct, latched (74x137 style) and scan modes.
// o_ shows the decode of the post-edge latch/counter state with one cycle of latency.
module decoder_seq
   import decoder_pkg::*;
#(
   parameter int AW   = 4,
   parameter int OUTS = 16,
   parameter int LAST = OUTS - 1
) (
   input  logic             clk_sys,
   input  logic             rst_,
   input  logic             en1_,
   input  logic             en2_,
   input  logic [1:0]       mode,
   input  logic [AW-1:0]    a,
   input  logic             le,
   input  logic             start,
   input  logic             step,
   output logic [0:OUTS-1]  o_,
   output logic             busy,
   output logic             wrap
);

   localparam logic [AW-1:0] LAST_C = AW'(LAST);

   scan_st_t         r_state;
   logic [AW-1:0]    r_cnt;
   logic [AW-1:0]    r_latch;
   logic             r_wrap;
   logic [0:OUTS-1]  r_out;

   scan_st_t         w_state_nxt;
   logic [AW-1:0]    w_cnt_nxt;
   logic             w_wrap_nxt;
   logic [AW-1:0]    w_sel;
   logic             w_sel_vld;
   logic             w_dec_en;
   logic [OUTS-1:0]  w_hot;
   logic [0:OUTS-1]  w_out_nxt;

   // Scan FSM next state; leaving SCAN mode aborts a running scan without a wrap pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wrap_nxt  = 1'b0;
      if (mode != MODE_SCAN) begin
         if (r_state == ST_RUN) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = r_state;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (start) begin
                  w_cnt_nxt = '0;
               end else if (step) begin
                  if (r_cnt == LAST_C) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                     w_wrap_nxt  = 1'b1;
                  end else begin
                     w_cnt_nxt = r_cnt + AW'(1);
                  end
               end else begin
                  w_cnt_nxt = r_cnt;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Select the index to decode; the latch is transparent on its load cycle.
   always_comb begin
      w_sel     = a;
      w_sel_vld = 1'b0;
      case (mode)
         MODE_DIRECT: begin
            w_sel     = a;
            w_sel_vld = 1'b1;
         end
         MODE_LATCH: begin
            if (le) begin
               w_sel = a;
            end else begin
               w_sel = r_latch;
            end
            w_sel_vld = 1'b1;
         end
         MODE_SCAN: begin
            w_sel     = w_cnt_nxt;
            w_sel_vld = (w_state_nxt == ST_RUN);
         end
         default: begin
            w_sel     = a;
            w_sel_vld = 1'b0;
         end
      endcase
   end

   assign w_dec_en = w_sel_vld & ~en1_ & ~en2_;

   onehot_dec #(
      .AW   (AW),
      .OUTS (OUTS)
   ) u_dec (
      .i_addr (w_sel),
      .i_en   (w_dec_en),
      .o_hot  (w_hot)
   );

   // Invert to active low, mapping hot bit i onto o_[i].
   always_comb begin
      w_out_nxt = '1;
      for (int i = 0; i < OUTS; i++) begin
         w_out_nxt[i] = ~w_hot[i];
      end
   end

   // Register latch, scan state and outputs.
   always_ff @(posedge clk_sys or negedge rst_) begin
      if (!rst_) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_latch <= '0;
         r_wrap  <= 1'b0;
         r_out   <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wrap  <= w_wrap_nxt;
         r_out   <= w_out_nxt;
         if ((mode == MODE_LATCH) && le) begin
            r_latch <= a;
         end else begin
            r_latch <= r_latch;
         end
      end
   end

   assign o_   = r_out;
   assign busy = (r_state == ST_RUN);
   assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: a 16-line instance and a 10-line instance
// share stimulus; each step checks outputs one time unit after the rising edge.
module tb_decoder_seq;

   logic        clk_sys;
   logic        rst_;
   logic        en1_;
   logic        en2_;
   logic [1:0]  mode;
   logic [3:0]  a;
   logic        le;
   logic        start;
   logic        step;

   logic [0:15] o1;
   logic        busy1;
   logic        wrap1;
   logic [0:9]  o2;
   logic        busy2;
   logic        wrap2;

   int total = 0;
   int bad   = 0;

   decoder_seq #(.AW(4), .OUTS(16), .LAST(15)) u_dut16 (
      .clk_sys (clk_sys), .rst_ (rst_), .en1_ (en1_), .en2_ (en2_),
      .mode (mode), .a (a), .le (le), .start (start), .step (step),
      .o_ (o1), .busy (busy1), .wrap (wrap1)
   );

   decoder_seq #(.AW(4), .OUTS(10), .LAST(9)) u_dut10 (
      .clk_sys (clk_sys), .rst_ (rst_), .en1_ (en1_), .en2_ (en2_),
      .mode (mode), .a (a), .le (le), .start (start), .step (step),
      .o_ (o2), .busy (busy2), .wrap (wrap2)
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   function automatic logic [0:15] sel16(input int idx);
      logic [0:15] v;
      v = '1;
      v[idx] = 1'b0;
      return v;
   endfunction

   function automatic logic [0:9] sel10(input int idx);
      logic [0:9] v;
      v = '1;
      v[idx] = 1'b0;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_sys);
      #1;
   endtask

   initial begin
      rst_  = 1'b0;
      en1_  = 1'b0;
      en2_  = 1'b0;
      mode  = 2'd0;
      a     = 4'd0;
      le    = 1'b0;
      start = 1'b0;
      step  = 1'b0;
      #11;
      chk("rst_o", o1, 16'hFFFF);
      chk("rst_busy", {15'd0, busy1}, 16'd0);
      chk("rst_o10", {6'd0, o2}, {6'd0, 10'h3FF});
      #1 rst_ = 1'b1;

      // Get a scan running, then pull reset mid-cycle.
      mode = 2'd2; start = 1'b1;
      cyc();
      start = 1'b0;
      chk("pre_busy", {15'd0, busy1}, 16'd1);
      chk("pre_o", o1, sel16(0));
      #2 rst_ = 1'b0;
      #1;
      chk("async_o", o1, 16'hFFFF);
      chk("async_busy", {15'd0, busy1}, 16'd0);
      chk("async_wrap", {15'd0, wrap1}, 16'd0);
      chk("async_o10", {6'd0, o2}, {6'd0, 10'h3FF});
      #1 rst_ = 1'b1;

      // Direct decode.
      mode = 2'd0; a = 4'd5;
      cyc();
      chk("dir_5", o1, sel16(5));
      a = 4'd15;
      cyc();
      chk("dir_15", o1, sel16(15));

      // Enable gating.
      a = 4'd3; en2_ = 1'b1;
      cyc();
      chk("en2_off", o1, 16'hFFFF);
      en2_ = 1'b0;
      cyc();
      chk("en2_on", o1, sel16(3));
      en1_ = 1'b1;
      cyc();
      chk("en1_off", o1, 16'hFFFF);
      en1_ = 1'b0;

      // Latch mode.
      mode = 2'd1; a = 4'd9; le = 1'b1;
      cyc();
      chk("lat_load", o1, sel16(9));
      a = 4'd2; le = 1'b0;
      cyc();
      chk("lat_hold1", o1, sel16(9));
      cyc();
      chk("lat_hold2", o1, sel16(9));
      le = 1'b1;
      cyc();
      chk("lat_reload", o1, sel16(2));
      le = 1'b0;

      // Reserved mode blanks outputs; latch survives.
      mode = 2'd3; a = 4'd4;
      cyc();
      chk("rsvd_o", o1, 16'hFFFF);
      mode = 2'd1;
      cyc();
      chk("rsvd_latch", o1, sel16(2));

      // Full scan; the 10-line instance wraps after index 9.
      mode = 2'd2; start = 1'b1;
      cyc();
      start = 1'b0;
      chk("scan_0", o1, sel16(0));
      chk("scan_busy0", {15'd0, busy1}, 16'd1);
      chk("scan10_0", {6'd0, o2}, {6'd0, sel10(0)});
      step = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (k < 16) begin
            chk("scan_o", o1, sel16(k));
            chk("scan_wrap", {15'd0, wrap1}, 16'd0);
         end else begin
            chk("scan_end_o", o1, 16'hFFFF);
            chk("scan_end_wrap", {15'd0, wrap1}, 16'd1);
            chk("scan_end_busy", {15'd0, busy1}, 16'd0);
         end
         if (k < 10) begin
            chk("scan10_o", {6'd0, o2}, {6'd0, sel10(k)});
         end else if (k == 10) begin
            chk("scan10_wrap", {15'd0, wrap2}, 16'd1);
            chk("scan10_end_o", {6'd0, o2}, {6'd0, 10'h3FF});
         end else begin
            chk("scan10_idle_wrap", {15'd0, wrap2}, 16'd0);
            chk("scan10_idle_busy", {15'd0, busy2}, 16'd0);
         end
      end
      step = 1'b0;
      cyc();
      chk("post_wrap", {15'd0, wrap1}, 16'd0);
      step = 1'b1;
      cyc();
      chk("idle_step_o", o1, 16'hFFFF);
      chk("idle_step_busy", {15'd0, busy1}, 16'd0);
      step = 1'b0;

      // Start beats a simultaneous step.
      start = 1'b1;
      cyc();
      start = 1'b0; step = 1'b1;
      for (int k = 0; k < 7; k++) cyc();
      chk("corner_7", o1, sel16(7));
      start = 1'b1;
      cyc();
      start = 1'b0; step = 1'b0;
      chk("corner_restart", o1, sel16(0));
      chk("corner_busy", {15'd0, busy1}, 16'd1);
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk("corner_step1", o1, sel16(1));

      // Leaving SCAN aborts without wrap.
      mode = 2'd0; a = 4'd6;
      cyc();
      chk("abort_busy", {15'd0, busy1}, 16'd0);
      chk("abort_wrap", {15'd0, wrap1}, 16'd0);
      chk("abort_o", o1, sel16(6));
      mode = 2'd2;
      cyc();
      chk("abort_idle_o", o1, 16'hFFFF);

      // Out-of-range address on the 10-line instance.
      mode = 2'd0; a = 4'd12;
      cyc();
      chk("oor10_o", {6'd0, o2}, {6'd0, 10'h3FF});
      chk("oor16_o", o1, sel16(12));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
